spi_apb_bridge: RTL and testbench

SPI-slave-to-APB-master bridge that lets an external host drive the debug APB port of the CPU access block. It deserialises 2- or 3-byte SPI frames into single APB read or write transfers, then returns read data on MISO in the same frame. It sits directly upstream of the CPU access block: its APB master outputs connect to that block's PSEL/PADDR/PENABLE/PWRITE/PWDATA, and it consumes that block's PRDATA/PREADY.

---
 rtl/spi_apb_bridge.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_spi_apb_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_bridge.sv
// SPI-slave (mode 0) to APB-master bridge. Each 2- or 3-byte SPI frame
// produces at most one APB read or write. Read data goes back on MISO
// during byte 2 of the same frame.
module spi_apb_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       SCK,
    input  logic       CS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    output logic       BUSY,
    output logic       ERR
);

    localparam logic [7:0] CMD_WR   = 8'h80;
    localparam logic [7:0] CMD_RD   = 8'h00;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_t;

    // Synchroniser stages: _p0/_p1 resolve metastability, _p2 is the edge reference
    logic sck_p0, sck_p1, sck_p2;
    logic cs_n_p0, cs_n_p1, cs_n_p2;
    logic mosi_p0, mosi_p1;

    logic sck_rise, sck_fall, cs_fall, cs_rise;

    // Frame state
    logic       active;      // inside a frame (between CS_N edges)
    logic       frame_ok;    // command byte was a legal read/write
    logic       is_wr;
    logic [2:0] bit_cnt;
    logic [1:0] byte_idx;
    logic       byte_end;    // next SCK fall ends a byte: load instead of shift
    logic [7:0] rx_sh;
    logic [7:0] miso_sh;
    logic [7:0] next_byte;
    logic [7:0] byte_val;
    logic [7:0] addr_sh;
    logic [7:0] wdata_sh;
    logic       err_q;

    // Read-return bookkeeping for the current frame
    logic       rd_wait;     // this frame's read is outstanding and not yet late
    logic       rd_ready;    // this frame's read data is in rd_buf
    logic [7:0] rd_buf;
    logic [7:0] rd_val;

    // Launch handoff between frame logic and APB FSM
    logic       pend;
    logic       pend_cur;    // pending launch belongs to the current frame
    logic       pend_wr;
    logic       xfer_cur;    // transfer in flight belongs to the current frame

    apb_state_t state_q, state_d;
    logic [7:0] tcnt;
    logic       start, apb_done, apb_tmo;

    logic shift_en, fall_en, byte_done, launch_req, late_hit, rd_done;

    // Two-flop synchronisers plus an edge-reference flop for SCK and CS_N
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sck_p0  <= 1'b0;
            sck_p1  <= 1'b0;
            sck_p2  <= 1'b0;
            cs_n_p0 <= 1'b1;
            cs_n_p1 <= 1'b1;
            cs_n_p2 <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sck_p0  <= SCK;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            cs_n_p0 <= CS_N;
            cs_n_p1 <= cs_n_p0;
            cs_n_p2 <= cs_n_p1;
            mosi_p0 <= MOSI;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sck_rise = sck_p1 & ~sck_p2;
    assign sck_fall = ~sck_p1 & sck_p2;
    assign cs_fall  = ~cs_n_p1 & cs_n_p2;
    assign cs_rise  = cs_n_p1 & ~cs_n_p2;

    assign shift_en   = active && !cs_fall && !cs_rise && sck_rise;
    assign fall_en    = active && !cs_fall && !cs_rise && sck_fall;
    assign byte_val   = {rx_sh[6:0], mosi_p1};
    assign byte_done  = shift_en && (bit_cnt == 3'd7);
    assign launch_req = byte_done && frame_ok &&
                        (((byte_idx == 2'd1) && !is_wr) || ((byte_idx == 2'd2) && is_wr));
    // Byte 2 of a read frame starting while the read is still outstanding
    assign late_hit   = shift_en && (bit_cnt == 3'd0) && (byte_idx == 2'd2) && rd_wait;
    assign rd_val     = apb_tmo ? 8'hFF : PRDATA;
    assign rd_done    = apb_done && !PWRITE && xfer_cur && rd_wait && !cs_fall && !late_hit;

    // Value loaded into the MISO shifter at the start of the byte now indexed
    always_comb begin
        next_byte = 8'h00;
        if ((byte_idx == 2'd2) && frame_ok && !is_wr) begin
            next_byte = rd_ready ? rd_buf : 8'hFF;
        end
    end

    // Frame sequencing, command decode, MISO shifter and sticky error flag
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            active   <= 1'b0;
            frame_ok <= 1'b0;
            is_wr    <= 1'b0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            byte_end <= 1'b0;
            miso_sh  <= 8'h00;
            err_q    <= 1'b0;
            rd_wait  <= 1'b0;
            rd_ready <= 1'b0;
        end else begin
            if (cs_fall) begin
                active   <= 1'b1;
                frame_ok <= 1'b1;
                is_wr    <= 1'b0;
                bit_cnt  <= 3'd0;
                byte_idx <= 2'd0;
                byte_end <= 1'b0;
                miso_sh  <= 8'hA5;
                err_q    <= 1'b0;
                rd_wait  <= 1'b0;
                rd_ready <= 1'b0;
            end else if (cs_rise) begin
                active   <= 1'b0;
                bit_cnt  <= 3'd0;
                byte_end <= 1'b0;
                miso_sh  <= 8'h00;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (late_hit) begin
                    err_q   <= 1'b1;
                    rd_wait <= 1'b0;
                end
                if (byte_done) begin
                    byte_end <= 1'b1;
                    if (byte_idx != 2'd3) begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                    if (byte_idx == 2'd0) begin
                        if (byte_val == CMD_WR) begin
                            is_wr <= 1'b1;
                        end else if (byte_val != CMD_RD) begin
                            frame_ok <= 1'b0;
                            err_q    <= 1'b1;
                        end
                    end
                    if (launch_req && !is_wr) begin
                        rd_wait <= 1'b1;
                    end
                end
            end else if (fall_en) begin
                if (byte_end) begin
                    byte_end <= 1'b0;
                    miso_sh  <= next_byte;
                end else begin
                    miso_sh <= {miso_sh[6:0], 1'b0};
                end
            end
            if (rd_done) begin
                rd_wait  <= 1'b0;
                rd_ready <= 1'b1;
                if (active && !cs_rise && (byte_idx == 2'd2)) begin
                    miso_sh <= rd_val;
                end
            end
            if (apb_tmo) begin
                err_q <= 1'b1;
            end
        end
    end

    // Unreset datapath registers: receive shifter, address/data shadows, read buffer
    always_ff @(posedge PCLK) begin
        if (shift_en) begin
            rx_sh <= byte_val;
        end
        if (byte_done && frame_ok && (byte_idx == 2'd1)) begin
            addr_sh <= byte_val;
        end
        if (byte_done && frame_ok && is_wr && (byte_idx == 2'd2)) begin
            wdata_sh <= byte_val;
        end
        if (rd_done) begin
            rd_buf <= rd_val;
        end
    end

    // One-deep pending launch; APB address/data/direction captured on leaving IDLE
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pend     <= 1'b0;
            pend_cur <= 1'b0;
            pend_wr  <= 1'b0;
            xfer_cur <= 1'b0;
            PADDR    <= 8'h00;
            PWDATA   <= 8'h00;
            PWRITE   <= 1'b0;
        end else begin
            if (start) begin
                pend     <= 1'b0;
                xfer_cur <= pend_cur;
                PADDR    <= addr_sh;
                PWDATA   <= wdata_sh;
                PWRITE   <= pend_wr;
            end
            if (launch_req) begin
                pend     <= 1'b1;
                pend_cur <= 1'b1;
                pend_wr  <= is_wr;
            end
            if (cs_fall) begin
                pend_cur <= 1'b0;
                xfer_cur <= 1'b0;
            end
        end
    end

    // APB state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ACCESS-phase cycle counter for the PREADY timeout
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tcnt <= 8'd0;
        end else if (state_q == ST_ACCESS) begin
            tcnt <= tcnt + 8'd1;
        end else begin
            tcnt <= 8'd0;
        end
    end

    // APB next-state and bus control decode
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        apb_done = 1'b0;
        apb_tmo  = 1'b0;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend) begin
                    start   = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                PSEL    = 1'b1;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    apb_done = 1'b1;
                    state_d  = ST_IDLE;
                end else if (tcnt == TMO_LAST) begin
                    apb_done = 1'b1;
                    apb_tmo  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign BUSY = (state_q != ST_IDLE);
    assign MISO = miso_sh[7];
    assign ERR  = err_q;

endmodule

// File: tb/tb_spi_apb_bridge.sv
// Bench for spi_apb_bridge: SPI host driver, APB slave model and scoreboards
// for APB transfers and returned MISO bytes.
module tb_spi_apb_bridge;

    localparam int TMO  = 16;
    localparam int HALF = 80;   // SCK half period, ns
    localparam int GAP  = 400;  // idle time between bytes, ns

    logic       PCLK = 1'b0;
    logic       PRESETn, SCK, CS_N, MOSI, MISO;
    logic       PSEL, PENABLE, PWRITE, PREADY, BUSY, ERR;
    logic [7:0] PADDR, PWDATA, PRDATA;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        int         len;
    } apb_exp_t;

    apb_exp_t   apb_q[$];
    logic [7:0] miso_q[$];

    int   n_chk  = 0;
    int   n_pass = 0;
    int   ready_lat;
    int   acc_cnt = 0;
    logic ready_en;
    logic mon_en;
    logic [7:0] prdata_v;
    logic err_at_start;

    always #5 PCLK = ~PCLK;

    spi_apb_bridge #(.TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI),
        .MISO(MISO), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .BUSY(BUSY), .ERR(ERR)
    );

    // APB slave: PREADY on the ready_lat-th ACCESS cycle when enabled
    assign PRDATA = prdata_v;
    assign PREADY = ready_en && PSEL && PENABLE && (acc_cnt == ready_lat - 1);

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // APB monitor: compares each transfer against the scoreboard head
    initial begin
        apb_exp_t cur;
        bit in_xfer;
        int acc, busy_cnt;
        in_xfer = 0; acc = 0; busy_cnt = 0;
        forever begin
            @(negedge PCLK);
            if (!mon_en) begin
                in_xfer = 0;
            end else begin
                if (PSEL && !PENABLE && !in_xfer) begin
                    if (apb_q.size() == 0) begin
                        chk("apb_unexpected_psel", PSEL, 0);
                    end else begin
                        cur = apb_q.pop_front();
                        in_xfer = 1; acc = 0; busy_cnt = 0;
                        chk("setup_pwrite", PWRITE, cur.wr);
                        chk("setup_paddr", PADDR, cur.addr);
                        if (cur.wr) chk("setup_pwdata", PWDATA, cur.data);
                    end
                end
                if (in_xfer) begin
                    if (BUSY) busy_cnt++;
                    if (PSEL && PENABLE) begin
                        acc++;
                        chk("access_hold", {PWRITE, PADDR}, {cur.wr, cur.addr});
                    end
                    if (!PSEL) begin
                        chk("access_len", acc, cur.len);
                        chk("busy_len", busy_cnt, cur.len + 1);
                        in_xfer = 0;
                    end
                end
            end
        end
    end

    task automatic spi_byte(input logic [7:0] tx, input int nbits);
        logic [7:0] rx;
        logic [7:0] e;
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = tx[i];
            #HALF;
            rx[i] = MISO;
            SCK = 1'b1;
            #HALF;
            SCK = 1'b0;
        end
        if (nbits == 8) begin
            if (miso_q.size() == 0) begin
                chk("miso_q_underrun", miso_q.size(), 1);
            end else begin
                e = miso_q.pop_front();
                chk("miso_byte", rx, e);
            end
        end
    endtask

    task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int nb2, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2);
        miso_q.push_back(e0);
        miso_q.push_back(e1);
        if (nb2 == 8) miso_q.push_back(e2);
        CS_N = 1'b0;
        #HALF;
        err_at_start = ERR;
        spi_byte(b0, 8);
        #GAP;
        spi_byte(b1, 8);
        #GAP;
        spi_byte(b2, nb2);
        #HALF;
        CS_N = 1'b1;
        #300;
        chk("miso_idle", MISO, 0);
    endtask

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        apb_exp_t t;
        bit got;
        PRESETn = 1'b0; SCK = 1'b0; CS_N = 1'b1; MOSI = 1'b0;
        ready_en = 1'b1; ready_lat = 1; prdata_v = 8'h00; mon_en = 1'b1;
        err_at_start = 1'b0;
        #23;
        chk("rst_miso", MISO, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 8'h00);
        chk("rst_pwdata", PWDATA, 8'h00);
        chk("rst_busy", BUSY, 0);
        chk("rst_err", ERR, 0);
        #20 PRESETn = 1'b1;
        repeat (5) @(posedge PCLK);

        // Write 0x80,0x0A,0x3C with PREADY on the third ACCESS cycle
        ready_lat = 3;
        t = '{wr: 1'b1, addr: 8'h0A, data: 8'h3C, len: 3}; apb_q.push_back(t);
        spi_frame(8'h80, 8'h0A, 8'h3C, 8, 8'hA5, 8'h00, 8'h00);
        chk("wr_err", ERR, 0);

        // Read 0x00,0x09 with PRDATA 0x5E after two ACCESS cycles
        ready_lat = 2; prdata_v = 8'h5E;
        t = '{wr: 1'b0, addr: 8'h09, data: 8'h00, len: 2}; apb_q.push_back(t);
        spi_frame(8'h00, 8'h09, 8'hC3, 8, 8'hA5, 8'h00, 8'h5E);
        chk("rd_err", ERR, 0);

        // Invalid command: no transfer, sticky error
        spi_frame(8'h41, 8'h0A, 8'h00, 8, 8'hA5, 8'h00, 8'h00);
        chk("inv_err", ERR, 1);

        // Read with PREADY never asserted: timeout after TMO ACCESS cycles
        ready_en = 1'b0; prdata_v = 8'h12;
        t = '{wr: 1'b0, addr: 8'h33, data: 8'h00, len: TMO}; apb_q.push_back(t);
        spi_frame(8'h00, 8'h33, 8'h00, 8, 8'hA5, 8'h00, 8'hFF);
        chk("tmo_err_cleared", err_at_start, 0);
        chk("tmo_err", ERR, 1);
        ready_en = 1'b1;

        // Write frame aborted after 4 bits of byte 2: no transfer
        spi_frame(8'h80, 8'h0B, 8'h5A, 4, 8'hA5, 8'h00, 8'h00);
        chk("part_err_cleared", err_at_start, 0);
        chk("part_no_busy", BUSY, 0);

        // Following write completes normally
        ready_lat = 1;
        t = '{wr: 1'b1, addr: 8'h0C, data: 8'h77, len: 1}; apb_q.push_back(t);
        spi_frame(8'h80, 8'h0C, 8'h77, 8, 8'hA5, 8'h00, 8'h00);
        chk("post_part_err", ERR, 0);

        // Reset pulse during ACCESS of a read
        ready_en = 1'b0; mon_en = 1'b0;
        miso_q.push_back(8'hA5);
        miso_q.push_back(8'h00);
        CS_N = 1'b0;
        #HALF;
        spi_byte(8'h00, 8);
        spi_byte(8'h21, 8);
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge PCLK);
            if (PENABLE) got = 1;
        end
        chk("rst_wait_access", got, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_psel", PSEL, 0);
        chk("arst_penable", PENABLE, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_miso", MISO, 0);
        CS_N = 1'b1;
        #100 PRESETn = 1'b1;
        ready_en = 1'b1;
        repeat (5) @(posedge PCLK);
        mon_en = 1'b1;

        // Normal write after reset
        ready_lat = 2;
        t = '{wr: 1'b1, addr: 8'h0D, data: 8'h99, len: 2}; apb_q.push_back(t);
        spi_frame(8'h80, 8'h0D, 8'h99, 8, 8'hA5, 8'h00, 8'h00);
        chk("post_rst_err", ERR, 0);

        repeat (20) @(posedge PCLK);
        chk("apb_q_left", apb_q.size(), 0);
        chk("miso_q_left", miso_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
